// File: rtl/mult_div_seq.sv
// Sequential 32x32 multiply / divide unit with HI/LO registers, 32 busy cycles per op.
// Define MULT_DIV_SEQ_DIVIDE_EN to build the iterative divider; otherwise divides clear HI/LO.
module mult_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  mult_func,
  output logic [31:0] c_mult,
  output logic        pause_out
);

  localparam logic [3:0] MULT_NOTHING       = 4'd0;
  localparam logic [3:0] MULT_READ_LO       = 4'd1;
  localparam logic [3:0] MULT_READ_HI       = 4'd2;
  localparam logic [3:0] MULT_WRITE_LO      = 4'd3;
  localparam logic [3:0] MULT_WRITE_HI      = 4'd4;
  localparam logic [3:0] MULT_MULT          = 4'd5;
  localparam logic [3:0] MULT_SIGNED_MULT   = 4'd6;
  localparam logic [3:0] MULT_DIVIDE        = 4'd7;
  localparam logic [3:0] MULT_SIGNED_DIVIDE = 4'd8;

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_BUSY = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] acc_cur, mult_step, step, mult_res;
  logic [32:0] sum;
  logic        sgn;
  logic [31:0] a_mag, b_mag;
`ifdef MULT_DIV_SEQ_DIVIDE_EN
  logic        div_q, div_d, neg_rem_q, neg_rem_d;
  logic [33:0] diff;
  logic [63:0] div_step;
`endif

  // First busy step seeds the accumulator from the latched A operand.
  assign acc_cur   = (cnt_q == '0) ? {32'b0, a_q} : acc_q;
  assign sum       = {1'b0, acc_cur[63:32]} + (acc_cur[0] ? {1'b0, b_q} : 33'b0);
  assign mult_step = {sum, acc_cur[31:1]};
  assign mult_res  = neg_q ? -step : step;

`ifdef MULT_DIV_SEQ_DIVIDE_EN
  // Restoring step: acc = {remainder, dividend/quotient bits}.
  assign diff     = {1'b0, acc_cur[63:31]} - {2'b0, b_q};
  assign div_step = diff[33] ? {acc_cur[62:0], 1'b0} : {diff[31:0], acc_cur[30:0], 1'b1};
  assign step     = div_q ? div_step : mult_step;
`else
  assign step     = mult_step;
`endif

  assign sgn   = (mult_func == MULT_SIGNED_MULT) || (mult_func == MULT_SIGNED_DIVIDE);
  assign a_mag = (sgn && a[31]) ? -a : a;
  assign b_mag = (sgn && b[31]) ? -b : b;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
`ifdef MULT_DIV_SEQ_DIVIDE_EN
    div_d     = div_q;
    neg_rem_d = neg_rem_q;
`endif
    if (state_q == STATE_IDLE) begin
      case (mult_func)
        MULT_WRITE_LO: lo_d = a;
        MULT_WRITE_HI: hi_d = a;
        MULT_MULT, MULT_SIGNED_MULT: begin
          state_d = STATE_BUSY;
          cnt_d   = '0;
          a_d     = a_mag;
          b_d     = b_mag;
          neg_d   = sgn & (a[31] ^ b[31]);
`ifdef MULT_DIV_SEQ_DIVIDE_EN
          div_d     = 1'b0;
          neg_rem_d = 1'b0;
`endif
        end
        MULT_DIVIDE, MULT_SIGNED_DIVIDE: begin
          if (b != '0) begin
`ifdef MULT_DIV_SEQ_DIVIDE_EN
            state_d   = STATE_BUSY;
            cnt_d     = '0;
            a_d       = a_mag;
            b_d       = b_mag;
            neg_d     = sgn & (a[31] ^ b[31]);
            div_d     = 1'b1;
            neg_rem_d = sgn & a[31];
`else
            hi_d = '0;
            lo_d = '0;
`endif
          end
        end
        default: ;
      endcase
    end else begin
      acc_d = step;
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        state_d = STATE_IDLE;
`ifdef MULT_DIV_SEQ_DIVIDE_EN
        if (div_q) begin
          lo_d = neg_q ? -step[31:0] : step[31:0];
          hi_d = neg_rem_q ? -step[63:32] : step[63:32];
        end else begin
          {hi_d, lo_d} = mult_res;
        end
`else
        {hi_d, lo_d} = mult_res;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STATE_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
`ifdef MULT_DIV_SEQ_DIVIDE_EN
      div_q     <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
`ifdef MULT_DIV_SEQ_DIVIDE_EN
      div_q     <= div_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  always_comb begin
    case (mult_func)
      MULT_READ_LO: c_mult = lo_q;
      MULT_READ_HI: c_mult = hi_q;
      default:      c_mult = '0;
    endcase
  end

  assign pause_out = !rst && (state_q == STATE_BUSY) && (mult_func != MULT_NOTHING);

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq: driver pushes expected read data, monitor pops on unpaused reads.
module tb_mult_div_seq;

  localparam logic [3:0] NOP  = 4'd0;
  localparam logic [3:0] RDLO = 4'd1;
  localparam logic [3:0] RDHI = 4'd2;
  localparam logic [3:0] WRLO = 4'd3;
  localparam logic [3:0] WRHI = 4'd4;
  localparam logic [3:0] MUL  = 4'd5;
  localparam logic [3:0] SMUL = 4'd6;
  localparam logic [3:0] DIV  = 4'd7;
  localparam logic [3:0] SDIV = 4'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [3:0]  mult_func;
  logic [31:0] c_mult;
  logic        pause_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] hi_m = '0, lo_m = '0;

  mult_div_seq dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .mult_func(mult_func),
    .c_mult(c_mult), .pause_out(pause_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: a read that is not stalled delivers data this cycle.
  always @(negedge clk) begin
    if (rst === 1'b0 && pause_out === 1'b0 && (mult_func == RDLO || mult_func == RDHI)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read actual=%h required=<none>", c_mult);
      end else begin
        chk(mult_func == RDLO ? "read_lo" : "read_hi", c_mult, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic [3:0] f, input logic [31:0] av, input logic [31:0] bv);
    @(posedge clk);
    #1;
    mult_func = f;
    a = av;
    b = bv;
  endtask

  task automatic issue_read(input logic [3:0] f);
    exp_q.push_back(f == RDLO ? lo_m : hi_m);
    drive(f, $urandom, $urandom);
  endtask

  // Reference: plain 64-bit arithmetic on the architectural HI/LO pair.
  task automatic model_op(input logic [3:0] f, input logic [31:0] av, input logic [31:0] bv,
                          output bit busy);
    longint sa, sb, q, r;
    logic [63:0] p;
    busy = 1'b0;
    sa = $signed(av);
    sb = $signed(bv);
    case (f)
      MUL:  begin p = {32'b0, av} * {32'b0, bv}; {hi_m, lo_m} = p; busy = 1'b1; end
      SMUL: begin p = sa * sb; {hi_m, lo_m} = p; busy = 1'b1; end
      DIV, SDIV: begin
        if (bv != 0) begin
`ifdef MULT_DIV_SEQ_DIVIDE_EN
          if (f == DIV) begin
            lo_m = av / bv;
            hi_m = av % bv;
          end else begin
            q = sa / sb;
            r = sa % sb;
            lo_m = q[31:0];
            hi_m = r[31:0];
          end
          busy = 1'b1;
`else
          lo_m = '0;
          hi_m = '0;
`endif
        end
      end
      WRLO: lo_m = av;
      WRHI: hi_m = av;
      default: ;
    endcase
  endtask

  task automatic count_pause(input string name, input int exp_n);
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pause_out) n++;
      else break;
    end
    chk(name, n, exp_n);
  endtask

  task automatic run_op(input logic [3:0] f, input logic [31:0] av, input logic [31:0] bv);
    bit busy;
    model_op(f, av, bv, busy);
    drive(f, av, bv);
    issue_read(RDLO);
    count_pause("pause_cycles", busy ? 32 : 0);
    issue_read(RDHI);
    drive(NOP, '0, '0);
  endtask

  task automatic run_pair(input logic [3:0] f1, input logic [31:0] a1, input logic [31:0] b1,
                          input logic [3:0] f2, input logic [31:0] a2, input logic [31:0] b2);
    bit busy;
    model_op(f1, a1, b1, busy);
    drive(f1, a1, b1);
    drive(f2, a2, b2);
    count_pause("held_cmd_pause", busy ? 32 : 0);
    model_op(f2, a2, b2, busy);
    issue_read(RDLO);
    count_pause("second_op_pause", busy ? 32 : 0);
    issue_read(RDHI);
    drive(NOP, '0, '0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  logic [3:0] ops[6] = '{MUL, SMUL, DIV, SDIV, WRLO, WRHI};

  initial begin
    rst = 1'b1;
    mult_func = NOP;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    issue_read(RDLO);
    issue_read(RDHI);
    drive(NOP, '0, '0);

    run_op(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("umul_hi_model", hi_m, 32'hFFFF_FFFE);
    run_op(SMUL, 32'hFFFF_FFFD, 32'd7);
    run_op(SDIV, 32'hFFFF_FFF9, 32'd2);
    run_op(SDIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(WRLO, 32'h0000_1234, 32'd0);
    run_op(DIV, 32'd55, 32'd0);
    run_op(DIV, 32'd9, 32'd2);

    // Reset during a multiply aborts it and clears HI/LO.
    run_op(WRHI, 32'hDEAD_BEEF, 32'd0);
    drive(MUL, 32'd5, 32'd6);
    drive(NOP, '0, '0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    mult_func = RDLO;
    @(negedge clk);
    chk("pause_in_reset", pause_out, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mult_func = NOP;
    hi_m = '0;
    lo_m = '0;
    issue_read(RDLO);
    @(negedge clk);
    chk("pause_after_reset", pause_out, 1'b0);
    issue_read(RDHI);
    drive(NOP, '0, '0);

    // Unused codes act as NOTHING: no output, no stall, no state change.
    run_op(WRLO, 32'hA5A5_0001, 32'd0);
    for (int c = 9; c < 16; c++) begin
      drive(4'(c), $urandom, $urandom);
      @(negedge clk);
      chk("unused_code_out", c_mult, 32'h0);
      chk("unused_code_pause", pause_out, 1'b0);
    end
    drive(NOP, '0, '0);
    @(negedge clk);
    chk("nop_out", c_mult, 32'h0);
    issue_read(RDLO);
    drive(NOP, '0, '0);

    run_pair(MUL, 32'd1000, 32'd3000, SMUL, 32'hFFFF_FF00, 32'h0000_0100);
    run_pair(SDIV, 32'h8765_4321, 32'd13, DIV, 32'hFFFF_FFFF, 32'd16);

    for (int i = 0; i < 40; i++)
      run_op(ops[$urandom_range(0, 5)], rnd_operand(), rnd_operand());

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
